// File: rtl/arith_op_scheduler_pkg.sv
// Shared types for the arithmetic-unit scheduler: op codes, FSM states, latched command,
// and the result-mask / overflow-flag rules applied at capture.
package arith_op_scheduler_pkg;

  typedef enum logic [1:0] {
    OpAdd  = 2'd0,
    OpSub  = 2'd1,
    OpMul2 = 2'd2,
    OpDiv2 = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    op_e        op;
    logic       id;
  } cmd_t;

  // Keep only the result bits that are meaningful for each operation.
  function automatic logic [7:0] mask_result(input op_e op, input logic [7:0] raw);
    logic [7:0] res;
    res = raw;
    unique case (op)
      OpAdd:   res = {3'b000, raw[4:0]};
      OpSub:   res = {4'b0000, raw[3:0]};
      OpMul2:  res = raw;
      OpDiv2:  res = raw;
      default: res = raw;
    endcase
    return res;
  endfunction

  // Carry out, borrow, bit shifted out of the top, bit shifted out of the bottom.
  function automatic logic ovf_flag(input op_e op, input logic [3:0] x, input logic [3:0] y,
                                    input logic [7:0] raw);
    logic flag;
    flag = 1'b0;
    unique case (op)
      OpAdd:   flag = raw[4];
      OpSub:   flag = (x < y);
      OpMul2:  flag = y[3];
      OpDiv2:  flag = x[0];
      default: flag = 1'b0;
    endcase
    return flag;
  endfunction

endpackage

// File: rtl/arith_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. Grants combinationally while enabled; the priority pointer
// moves past the winner only when its request is actually taken.
module arith_op_scheduler_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // gnt is a subset of req, so any grant bit means the request was taken this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (|(req & gnt)) begin
      ptr_d = ~gnt[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/arith_op_scheduler.sv
// Shares one 4-bit arithmetic unit between two requesters: arbitrate, hold operands for a
// settle window, capture the masked result and overflow flag, return it on a response channel.
module arith_op_scheduler
  import arith_op_scheduler_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req_x,
  input  logic [7:0]       req_y,
  input  logic [3:0]       req_op,
  output logic [3:0]       alu_x,
  output logic [3:0]       alu_y,
  output logic [1:0]       alu_sel,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  output logic             rsp_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count,
  output logic             busy
);

  localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_sel;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [1:0]       gnt;
  logic             accept;
  logic             capture;
  logic             cap_flag;
  logic             cap_ovf;
  logic [7:0]       cap_data;
  logic [7:0]       rsp_data_q;
  logic             rsp_ovf_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  arith_op_scheduler_rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == StIdle),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);

  // Pick the granted requester's fields out of the packed request buses.
  always_comb begin
    cmd_sel.id = gnt[1];
    cmd_sel.x  = gnt[1] ? req_x[7:4] : req_x[3:0];
    cmd_sel.y  = gnt[1] ? req_y[7:4] : req_y[3:0];
    cmd_sel.op = op_e'(gnt[1] ? req_op[3:2] : req_op[1:0]);
  end

  assign capture  = (state_q == StSettle) && (settle_q == SettleLast);
  assign cap_data = mask_result(cmd_q.op, alu_out);
  assign cap_flag = ovf_flag(cmd_q.op, cmd_q.x, cmd_q.y, alu_out);
  assign cap_ovf  = capture && cap_flag;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StIdle: begin
        settle_d = '0;
        if (accept) begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (capture) begin
          settle_d = '0;
          state_d  = StResp;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear has priority, but an overflow captured in the same cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = cap_ovf ? CNT_W'(1) : '0;
    end else if (cap_ovf && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
    end else if (accept) begin
      cmd_q <= cmd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else if (capture) begin
      rsp_data_q <= cap_data;
      rsp_ovf_q  <= cap_flag;
      rsp_id_q   <= cmd_q.id;
    end
  end

  assign alu_x     = cmd_q.x;
  assign alu_y     = cmd_q.y;
  assign alu_sel   = cmd_q.op;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;
  assign ovf_count = cnt_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_arith_op_scheduler.sv
// Randomised bench for arith_op_scheduler: arithmetic unit model on alu_*, arithmetic
// reference for results, round-robin grant and saturating overflow count.
module tb_arith_op_scheduler;

  localparam int unsigned SETTLE = 1;
  localparam int unsigned CW     = 8;
  localparam int          CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [7:0]    req_x;
  logic [7:0]    req_y;
  logic [3:0]    req_op;
  logic [3:0]    alu_x;
  logic [3:0]    alu_y;
  logic [1:0]    alu_sel;
  logic [7:0]    alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [7:0]    rsp_data;
  logic          rsp_ovf;
  logic          ovf_clr;
  logic [CW-1:0] ovf_count;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int ptr;
  int exp_cnt;
  logic [7:0] last_data;
  logic       last_ovf;
  int         last_id;

  always #5 clk = ~clk;

  arith_op_scheduler #(
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_op    (req_op),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count),
    .busy      (busy)
  );

  // Arithmetic unit: add, sub, x2 and /2 of {Y,X}.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      2'd0:    alu_out = {4'b0, alu_x} + {4'b0, alu_y};
      2'd1:    alu_out = {4'b0, alu_x} - {4'b0, alu_y};
      2'd2:    alu_out = {alu_y, alu_x} << 1;
      default: alu_out = {alu_y, alu_x} >> 1;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {flag, data} from plain integer arithmetic.
  function automatic logic [8:0] ref_rsp(input int op, input int x, input int y);
    int v;
    int d;
    bit f;
    v = y * 16 + x;
    case (op)
      0:       begin d = x + y;               f = (x + y) > 15; end
      1:       begin d = (x - y + 16) % 16;   f = (x < y);      end
      2:       begin d = (v * 2) % 256;       f = (v >= 128);   end
      default: begin d = v / 2;               f = (v % 2) == 1; end
    endcase
    return {f, d[7:0]};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_alu_x"}, alu_x, 0);
    check({tag, "_alu_y"}, alu_y, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_ovf"}, rsp_ovf, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_count"}, ovf_count, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    ovf_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 0;
    exp_cnt = 0;
    @(posedge clk); #1;
  endtask

  // Entered at posedge+1 with the DUT idle; leaves at posedge+1 after the response handshake.
  task automatic run_cmd(input logic [1:0] v, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] op, input int hold, input bit clr);
    int g;
    int cop;
    logic [3:0] cx, cy;
    logic [8:0] r;
    logic seen;
    req_valid = v;
    req_x = x;
    req_y = y;
    req_op = op;
    g = (v == 2'b11) ? ptr : (v[1] ? 1 : 0);
    @(negedge clk);
    check("req_ready", req_ready, (g == 1) ? 2 : 1);
    @(posedge clk); #1;
    ptr = 1 - g;
    cx = g ? x[7:4] : x[3:0];
    cy = g ? y[7:4] : y[3:0];
    cop = g ? int'(op[3:2]) : int'(op[1:0]);
    r = ref_rsp(cop, int'(cx), int'(cy));
    for (int k = 1; k <= SETTLE; k++) begin
      if (clr && k == SETTLE) ovf_clr = 1'b1;
      @(negedge clk);
      check("alu_x", alu_x, cx);
      check("alu_y", alu_y, cy);
      check("alu_sel", alu_sel, cop);
      check("settle_valid", rsp_valid, 0);
      check("settle_ready", req_ready, 0);
      check("settle_busy", busy, 1);
      @(posedge clk); #1;
      ovf_clr = 1'b0;
    end
    if (clr) exp_cnt = r[8] ? 1 : 0;
    else if (r[8] && exp_cnt < CntMax) exp_cnt++;
    @(negedge clk);
    check("rsp_latency", rsp_valid, 1);
    seen = rsp_valid;
    for (int w = 0; w < 16 && !seen; w++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) begin
      check("rsp_timeout", seen, 1);
      do_reset();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, r[7:0]);
      check("stall_ovf", rsp_ovf, r[8]);
      check("stall_id", rsp_id, g);
      check("stall_ready", req_ready, 0);
      check("stall_busy", busy, 1);
      @(posedge clk); #1;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("rsp_data", rsp_data, r[7:0]);
    check("rsp_ovf", rsp_ovf, r[8]);
    check("rsp_id", rsp_id, g);
    check("ovf_count", ovf_count, exp_cnt);
    last_data = r[7:0];
    last_ovf = r[8];
    last_id = g;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic idle_gap(input int cycles);
    req_valid = 2'b00;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("gap_busy", busy, 0);
      check("gap_ready", req_ready, 0);
      check("gap_valid", rsp_valid, 0);
      check("hold_data", rsp_data, last_data);
      check("hold_ovf", rsp_ovf, last_ovf);
      check("hold_id", rsp_id, last_id);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_x = '0;
    req_y = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    ovf_clr = 1'b0;
    ptr = 0;
    exp_cnt = 0;
    last_data = '0;
    last_ovf = 1'b0;
    last_id = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_gap(2);

    // Directed vectors.
    run_cmd(2'b01, 8'h09, 8'h08, 4'b0000, 0, 0);
    idle_gap(1);
    check("t_add_data", rsp_data, 8'h11);
    check("t_add_ovf", rsp_ovf, 1);
    check("t_add_id", rsp_id, 0);
    check("t_add_count", ovf_count, 1);
    run_cmd(2'b10, 8'h30, 8'h50, 4'b0100, 0, 0);
    idle_gap(1);
    check("t_sub1_data", rsp_data, 8'h0E);
    check("t_sub1_ovf", rsp_ovf, 1);
    run_cmd(2'b01, 8'h07, 8'h02, 4'b0001, 0, 0);
    idle_gap(1);
    check("t_sub2_data", rsp_data, 8'h05);
    check("t_sub2_ovf", rsp_ovf, 0);
    run_cmd(2'b01, 8'h05, 8'h09, 4'b0010, 0, 0);
    idle_gap(1);
    check("t_mul2_data", rsp_data, 8'h2A);
    check("t_mul2_ovf", rsp_ovf, 1);
    run_cmd(2'b10, 8'h40, 8'h90, 4'b1100, 0, 0);
    idle_gap(1);
    check("t_div2_data", rsp_data, 8'h4A);
    check("t_div2_ovf", rsp_ovf, 0);

    // Response back-pressure for five cycles.
    run_cmd(2'b01, 8'h0C, 8'h07, 4'b0000, 5, 0);
    idle_gap(1);

    // Both requesters held valid: strict alternation from pointer 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_cmd(2'b11, 8'($urandom), 8'($urandom), 4'($urandom), 0, 0);
      check("rr_seq", rsp_id, i % 2);
    end
    idle_gap(1);

    // Reset pulsed mid-command: everything returns to zero, no response follows.
    req_valid = 2'b10;
    req_x = 8'hF0;
    req_y = 8'hF0;
    req_op = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    #2;
    rst_n = 1'b1;
    ptr = 0;
    exp_cnt = 0;
    last_data = '0;
    last_ovf = 1'b0;
    last_id = 0;
    @(posedge clk); #1;
    idle_gap(3);
    run_cmd(2'b10, 8'h30, 8'h50, 4'b0100, 0, 0);
    check("post_rst_count", ovf_count, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      run_cmd(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 4'($urandom),
              $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 2));
    end

    // Drive the counter into saturation, then clear it.
    for (int i = 0; i < CntMax + 5; i++) begin
      run_cmd(2'b01, 8'h0F, 8'h0F, 4'b0000, 0, 0);
    end
    check("sat_count", ovf_count, CntMax);
    req_valid = 2'b00;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("clr_count", ovf_count, 0);
    @(posedge clk); #1;
    run_cmd(2'b01, 8'h0F, 8'h0F, 4'b0000, 0, 1);
    check("clr_cap_count", ovf_count, 1);
    idle_gap(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
